// File: rtl/fir_pkg.sv
// Shared definitions for the generic FIR and its coefficient load path.
// Holds the loader state encoding, the frame header byte and the default geometry.
package fir_pkg;

  localparam int          NTAPS_DEF = 16;
  localparam int          TAP_W_DEF = 16;
  localparam logic [7:0]  HDR_DEF   = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    TAP_HI,
    TAP_LO,
    ZFILL,
    CHECK,
    DONE,
    ERR
  } ld_state_e;

endpackage

// File: rtl/fir_tap_bank.sv
// Dual-bank FIR coefficient store: the loader writes the shadow bank,
// and a commit pulse swaps it with the active bank that drives the filter.
module fir_tap_bank
  import fir_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEF,
  parameter int TAP_W  = TAP_W_DEF,
  parameter int ADDR_W = $clog2(NTAPS)
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              tap_we,
  input  logic [ADDR_W-1:0] tap_addr,
  input  logic [TAP_W-1:0]  tap_wdata,
  input  logic              commit,
  output logic [TAP_W-1:0]  taps [NTAPS],
  output logic              active_sel
);

  logic [TAP_W-1:0] bank [2][NTAPS];

  // NOTE: the banks are reset explicitly so the filter never runs on undefined
  // coefficients before the first good frame; a RAM macro would not allow this.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NTAPS; i++)
          bank[b][i] <= '0;
      active_sel <= 1'b0;
    end else begin
      if (tap_we)
        bank[!active_sel][tap_addr] <= tap_wdata;
      if (commit)
        active_sel <= !active_sel;
    end
  end

  always_comb begin
    for (int i = 0; i < NTAPS; i++)
      taps[i] = bank[active_sel][i];
  end

endmodule

// File: rtl/fir_tap_loader.sv
// Framed byte-stream coefficient loader: HDR, N, N taps (MSB first), XOR checksum.
// Writes the FIR shadow bank, zero-fills unused taps and commits only good frames.
module fir_tap_loader
  import fir_pkg::*;
#(
  parameter int         NTAPS  = NTAPS_DEF,
  parameter int         TAP_W  = TAP_W_DEF,
  parameter int         ADDR_W = $clog2(NTAPS),
  parameter logic [7:0] HDR    = HDR_DEF
) (
  input  logic                     Clk,
  input  logic                     reset_n,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic                     tap_we,
  output logic [ADDR_W-1:0]        tap_addr,
  output logic signed [TAP_W-1:0]  tap_wdata,
  output logic                     commit,
  output logic                     err,
  output logic                     busy
);

  localparam logic [7:0]        NTAPS_B   = 8'(NTAPS);
  localparam logic [ADDR_W:0]   NTAPS_N   = (ADDR_W + 1)'(NTAPS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NTAPS - 1);

  ld_state_e         state;
  logic [ADDR_W:0]   n_taps;
  logic [ADDR_W-1:0] index;
  logic [7:0]        csum;
  logic [7:0]        tap_hi;

  logic accept;
  logic last_tap;
  logic full_frame;

  assign accept     = s_valid && s_ready;
  assign last_tap   = (({1'b0, index} + 1'b1) == n_taps);
  assign full_frame = (n_taps == NTAPS_N);

  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; the strobes default low each cycle to make them single pulses.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      tap_we    <= 1'b0;
      tap_addr  <= '0;
      tap_wdata <= '0;
      commit    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      n_taps    <= '0;
      index     <= '0;
      csum      <= '0;
      tap_hi    <= '0;
    end else begin
      tap_we <= 1'b0;
      commit <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (accept && s_data == HDR) begin
            state <= COUNT;
            busy  <= 1'b1;
            csum  <= '0;
          end
        end

        COUNT: if (accept) begin
          if (s_data == 8'd0 || s_data > NTAPS_B) begin
            state   <= ERR;
            s_ready <= 1'b0;
            err     <= 1'b1;
          end else begin
            n_taps <= s_data[ADDR_W:0];
            index  <= '0;
            state  <= TAP_HI;
          end
        end

        TAP_HI: if (accept) begin
          tap_hi <= s_data;
          csum   <= csum ^ s_data;
          state  <= TAP_LO;
        end

        TAP_LO: if (accept) begin
          csum      <= csum ^ s_data;
          tap_we    <= 1'b1;
          tap_addr  <= index;
          tap_wdata <= TAP_W'({tap_hi, s_data});
          // A full frame leaves index parked on the last address instead of wrapping.
          if (!(last_tap && full_frame))
            index <= index + 1'b1;
          if (!last_tap) begin
            state <= TAP_HI;
          end else if (full_frame) begin
            state <= CHECK;
          end else begin
            state   <= ZFILL;
            s_ready <= 1'b0;
          end
        end

        ZFILL: begin
          tap_we    <= 1'b1;
          tap_addr  <= index;
          tap_wdata <= '0;
          if (index == LAST_ADDR) begin
            state   <= CHECK;
            s_ready <= 1'b1;
          end else begin
            index <= index + 1'b1;
          end
        end

        CHECK: if (accept) begin
          s_ready <= 1'b0;
          if (s_data == csum) begin
            state  <= DONE;
            commit <= 1'b1;
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end

        DONE, ERR: begin
          state   <= IDLE;
          busy    <= 1'b0;
          s_ready <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader driving a fir_tap_bank; checks every shadow
// write, commit/err pulses, zero-fill length, busy and the committed active bank.
module tb_fir_tap_loader;
  import fir_pkg::*;

  localparam int NTAPS  = 16;
  localparam int TAP_W  = 16;
  localparam int ADDR_W = 4;

  logic              Clk     = 1'b0;
  logic              reset_n = 1'b1;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data  = 8'h00;
  logic              s_ready;
  logic              tap_we;
  logic [ADDR_W-1:0] tap_addr;
  logic [TAP_W-1:0]  tap_wdata;
  logic              commit;
  logic              err;
  logic              busy;
  logic [TAP_W-1:0]  taps [NTAPS];
  logic              active_sel;

  always #5 Clk = ~Clk;

  fir_tap_loader #(.NTAPS(NTAPS), .TAP_W(TAP_W), .ADDR_W(ADDR_W), .HDR(8'hA5)) dut (
    .Clk(Clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .tap_we(tap_we), .tap_addr(tap_addr), .tap_wdata(tap_wdata),
    .commit(commit), .err(err), .busy(busy)
  );

  fir_tap_bank #(.NTAPS(NTAPS), .TAP_W(TAP_W), .ADDR_W(ADDR_W)) bank (
    .Clk(Clk), .reset_n(reset_n), .tap_we(tap_we), .tap_addr(tap_addr),
    .tap_wdata(tap_wdata), .commit(commit), .taps(taps), .active_sel(active_sel)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Passive monitor: logs every shadow write and counts strobes.
  logic [19:0] wr_log [$];
  int cyc = 0, last_wr_cyc = -100;
  int n_commit = 0, n_err = 0, n_zf = 0, n_late = 0;

  always @(negedge Clk) begin
    cyc++;
    if (tap_we) begin
      wr_log.push_back({tap_addr, tap_wdata});
      last_wr_cyc = cyc;
    end
    if (commit) begin
      n_commit++;
      if (cyc - last_wr_cyc < 1) n_late++;
    end
    if (err) n_err++;
    if (busy && !s_ready && !commit && !err) n_zf++;
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      s_valid = 1'b0;
      @(negedge Clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!s_ready) chk("ready_timeout", {31'd0, s_ready}, 32'd1);
    @(negedge Clk);
    s_valid = 1'b0;
  endtask

  // exp_n = accepted tap count (0 when the count byte is rejected).
  task automatic run_frame(input string name, input logic [7:0] bytes [$], input bit gap,
                           input int exp_n, input logic [15:0] exp_taps [$], input bit exp_ok);
    int b_wr, b_commit, b_err, b_zf, b_late, nw, n;
    logic [15:0] exp_d;
    b_wr = wr_log.size(); b_commit = n_commit; b_err = n_err; b_zf = n_zf; b_late = n_late;
    foreach (bytes[i]) send_byte(bytes[i], gap);
    chk({name, " pulse"}, {30'd0, commit, err}, exp_ok ? 32'd2 : 32'd1);
    n = 0;
    while (busy && n < 64) begin
      @(negedge Clk);
      n++;
    end
    chk({name, " busy_fall"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge Clk);
    chk({name, " ready_idle"}, {31'd0, s_ready}, 32'd1);
    chk({name, " commits"}, n_commit - b_commit, exp_ok ? 32'd1 : 32'd0);
    chk({name, " errs"}, n_err - b_err, exp_ok ? 32'd0 : 32'd1);
    chk({name, " late"}, n_late - b_late, 32'd0);
    nw = (exp_n > 0) ? NTAPS : 0;
    chk({name, " nwrites"}, wr_log.size() - b_wr, nw);
    chk({name, " zfill"}, n_zf - b_zf, (exp_n > 0) ? NTAPS - exp_n : 0);
    for (int a = 0; a < nw && b_wr + a < wr_log.size(); a++) begin
      exp_d = (a < exp_n) ? exp_taps[a] : 16'h0000;
      chk($sformatf("%s wr%0d", name, a), {12'd0, wr_log[b_wr + a]}, {12'd0, 4'(a), exp_d});
    end
    if (exp_ok)
      for (int a = 0; a < NTAPS; a++) begin
        exp_d = (a < exp_n) ? exp_taps[a] : 16'h0000;
        chk($sformatf("%s active%0d", name, a), {16'd0, taps[a]}, {16'd0, exp_d});
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  f [$];
    logic [15:0] t [$];
    logic [15:0] t_short [$];

    #2 reset_n = 1'b0;
    #20;
    chk("rst_outputs", {12'd0, s_ready, tap_we, tap_addr, tap_wdata, commit, err, busy}, 32'd0);
    @(negedge Clk);
    reset_n = 1'b1;
    #1 chk("rst_ready_low", {31'd0, s_ready}, 32'd0);
    @(negedge Clk);
    chk("ready_after_rst", {31'd0, s_ready}, 32'd1);

    // Full frame: taps 1..16, CK = XOR(1..16) = 0x10.
    f = '{8'hA5, 8'h10};
    t = {};
    for (int i = 1; i <= 16; i++) begin
      f.push_back(8'h00);
      f.push_back(8'(i));
      t.push_back(16'(i));
    end
    f.push_back(8'h10);
    run_frame("full", f, 1'b0, 16, t, 1'b1);

    // Short frame with sign extremes; CK = 7F^FF^80^00^FF^FF = 00.
    t_short = '{16'h7FFF, 16'h8000, 16'hFFFF};
    f = '{8'hA5, 8'h03, 8'h7F, 8'hFF, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'h00};
    run_frame("short", f, 1'b0, 3, t_short, 1'b1);

    // Same body, wrong checksum: writes still happen, active bank untouched.
    f = '{8'hA5, 8'h03, 8'h7F, 8'hFF, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'h55};
    run_frame("badck", f, 1'b0, 3, t_short, 1'b0);
    for (int a = 0; a < 3; a++)
      chk($sformatf("badck keep%0d", a), {16'd0, taps[a]}, {16'd0, t_short[a]});

    f = '{8'hA5, 8'h00};
    run_frame("cnt0", f, 1'b0, 0, t_short, 1'b0);
    f = '{8'hA5, 8'h11};
    run_frame("cnt17", f, 1'b0, 0, t_short, 1'b0);

    // Garbage before header, CK = 12^34 = 26; then the same with s_valid gaps.
    t = '{16'h1234};
    f = '{8'h00, 8'h3C, 8'hA5, 8'h01, 8'h12, 8'h34, 8'h26};
    run_frame("garbage", f, 1'b0, 1, t, 1'b1);
    run_frame("gapped", f, 1'b1, 1, t, 1'b1);

    // Reset after five tap bytes of a 16-tap frame.
    begin
      int b_commit, b_err;
      b_commit = n_commit; b_err = n_err;
      f = '{8'hA5, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
      foreach (f[i]) send_byte(f[i], 1'b0);
      chk("midrst busy_before", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      #1 chk("midrst outputs", {12'd0, s_ready, tap_we, tap_addr, tap_wdata, commit, err, busy}, 32'd0);
      repeat (3) @(negedge Clk);
      reset_n = 1'b1;
      repeat (2) @(negedge Clk);
      chk("midrst no_pulse", (n_commit - b_commit) + (n_err - b_err), 32'd0);
    end
    f = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h26};
    run_frame("after_rst", f, 1'b0, 1, t, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
